// File: rtl/counter_pkg.sv
// counter_pkg: shared width default and checker state encoding
package counter_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter that holds at all-ones; clr wins but still counts a coincident inc
module sat_counter #(
  parameter int ERR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 clr,
  output logic [ERR_WIDTH-1:0] count
);
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (clr) count <= ERR_WIDTH'(inc);
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/counter_checker.sv
// counter_checker: checks a sampled count stream increments by one each clock and reports lock/errors/wraps
module counter_checker #(
  parameter int WIDTH      = counter_pkg::DEF_WIDTH,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     value,
  input  logic                 clear_err,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic                 sticky_err,
  output logic                 wrap_pulse,
  output logic [WIDTH-1:0]     expected
);
  import counter_pkg::*;
  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam logic [RW-1:0] LAST = RW'(LOCK_COUNT - 1);
  state_t state, next;
  logic [RW-1:0] run;
  logic match, err_d, run_inc, run_clr;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE    ? ACQUIRE :
           state == ACQUIRE ? (match && run == LAST ? LOCKED : ACQUIRE) :
           match            ? LOCKED : ACQUIRE;
  always_comb begin
    match   = value == expected;
    err_d   = state == LOCKED && !match;
    run_inc = state == ACQUIRE && match;
    run_clr = state == IDLE || !match;
  end
  // expected always tracks the last sample so a jumped stream is re-acquired from its new origin
  always_ff @(posedge clk)
    if (reset) begin
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      sticky_err <= 1'b0;
      expected   <= '0;
    end else begin
      err_pulse  <= err_d;
      wrap_pulse <= state == LOCKED && match && value == '0;
      sticky_err <= err_d | (sticky_err & ~clear_err);
      expected   <= value + 1'b1;
    end
  assign locked = state == LOCKED;
  sat_counter #(.ERR_WIDTH(ERR_WIDTH)) errs (
    .clk(clk), .reset(reset), .inc(err_d), .clr(clear_err), .count(err_count)
  );
  sat_counter #(.ERR_WIDTH(RW)) runs (
    .clk(clk), .reset(reset), .inc(run_inc), .clr(run_clr), .count(run)
  );
endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: randomized stream checks against a history-based reference model
module tb_counter_checker;
  localparam int LC = 4;
  localparam int EW = 2;
  logic clk = 1'b0, reset = 1'b1, clear_err = 1'b0;
  logic [7:0] value = '0;
  logic locked, err_pulse, sticky_err, wrap_pulse;
  logic [EW-1:0] err_count;
  logic [7:0] expected;
  int checks = 0, passed = 0;
  logic m_valid, m_locked, m_ep, m_wp, m_sticky;
  int m_streak, m_errs;
  logic [7:0] m_prev, m_exp, cur;

  counter_checker #(.WIDTH(8), .LOCK_COUNT(LC), .ERR_WIDTH(EW)) dut (
    .clk(clk), .reset(reset), .value(value), .clear_err(clear_err), .locked(locked),
    .err_pulse(err_pulse), .err_count(err_count), .sticky_err(sticky_err),
    .wrap_pulse(wrap_pulse), .expected(expected)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] got();
    return {locked, err_pulse, err_count, sticky_err, wrap_pulse, expected};
  endfunction

  function automatic logic [13:0] want();
    return {m_locked, m_ep, 2'(m_errs > 3 ? 3 : m_errs), m_sticky, m_wp, m_exp};
  endfunction

  // model: counts consecutive good increments since the last break; errors only while locked
  function void model(logic [7:0] v, logic c, logic r);
    logic ok;
    m_ep = 0;
    m_wp = 0;
    if (r) begin
      {m_valid, m_locked, m_sticky} = '0;
      m_streak = 0;
      m_errs = 0;
      m_exp = 0;
      return;
    end
    ok = m_valid && v == 8'(m_prev + 8'd1);
    if (m_locked && !ok) begin
      m_ep = 1;
      m_locked = 0;
      m_streak = 0;
    end else if (m_locked) m_wp = v == 0;
    else if (!ok) m_streak = 0;
    else begin
      m_streak++;
      m_locked = m_streak == LC;
    end
    if (m_ep) begin
      m_errs = c ? 1 : m_errs + 1;
      m_sticky = 1;
    end else if (c) begin
      m_errs = 0;
      m_sticky = 0;
    end
    m_valid = 1;
    m_prev = v;
    m_exp = v + 8'd1;
  endfunction

  task automatic go(input logic [7:0] v, input logic c = 0, input logic r = 0);
    value = v;
    clear_err = c;
    reset = r;
    @(posedge clk);
    model(v, c, r);
    #1;
  endtask

  task automatic inc(input int n);
    repeat (n) begin
      cur++;
      go(cur);
    end
  endtask

  task automatic test_reset();
    go(8'h33, 1, 1);
    go(8'h34, 0, 1);
    checks++; if (got() !== 14'h0) $display("FAIL reset_outputs got %h want 0", got()); else passed++;
    checks++; if (want() !== 14'h0) $display("FAIL reset_model got %h want 0", want()); else passed++;
  endtask

  task automatic test_lock();
    cur = 8'($urandom);
    for (int i = 0; i < 200; i++) begin
      go(cur);
      checks++; if (got() !== want()) $display("FAIL lock_vec cyc=%0d got %h want %h", i, got(), want()); else passed++;
      checks++; if (locked !== (i >= LC)) $display("FAIL lock_time cyc=%0d got %b want %b", i, locked, i >= LC); else passed++;
      checks++; if (err_count !== 2'd0) $display("FAIL lock_errs cyc=%0d got %0d want 0", i, err_count); else passed++;
      cur++;
    end
    cur--;
  endtask

  task automatic test_wrap();
    while (cur != 8'hFF) inc(1);
    inc(1);
    checks++; if (wrap_pulse !== 1'b1) $display("FAIL wrap_hit got %b want 1", wrap_pulse); else passed++;
    checks++; if (err_pulse !== 1'b0) $display("FAIL wrap_err got %b want 0", err_pulse); else passed++;
    inc(1);
    checks++; if (wrap_pulse !== 1'b0) $display("FAIL wrap_once got %b want 0", wrap_pulse); else passed++;
    checks++; if (got() !== want()) $display("FAIL wrap_vec got %h want %h", got(), want()); else passed++;
  endtask

  task automatic test_counter_reset();
    while (cur != 8'h1C) inc(1);
    cur = 8'h00;
    go(cur);
    checks++; if ({err_pulse, err_count, sticky_err, locked} !== 5'b1_01_1_0)
      $display("FAIL creset_err got %b want 10110", {err_pulse, err_count, sticky_err, locked}); else passed++;
    inc(3);
    checks++; if ({err_pulse, locked} !== 2'b00) $display("FAIL creset_early got %b want 00", {err_pulse, locked}); else passed++;
    inc(1);
    checks++; if (locked !== 1'b1 || cur !== 8'h04) $display("FAIL creset_relock got %b@%h want 1@04", locked, cur); else passed++;
  endtask

  task automatic test_stuck();
    int n;
    cur++;
    go(cur, 1);
    while (cur != 8'h40) inc(1);
    n = 0;
    repeat (2) begin
      go(cur);
      n += int'(err_pulse);
    end
    checks++; if (n !== 1 || err_count !== 2'd1) $display("FAIL stuck_once got %0d/%0d want 1/1", n, err_count); else passed++;
    inc(3);
    checks++; if (locked !== 1'b0) $display("FAIL stuck_early got %b want 0", locked); else passed++;
    inc(1);
    checks++; if (locked !== 1'b1) $display("FAIL stuck_relock got %b want 1", locked); else passed++;
    checks++; if (got() !== want()) $display("FAIL stuck_vec got %h want %h", got(), want()); else passed++;
  endtask

  task automatic test_saturation();
    logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    int n;
    cur++;
    go(cur, 1);
    n = 0;
    for (int k = 0; k < 5; k++) begin
      cur += 8'd37;
      go(cur);
      n += int'(err_pulse);
      checks++; if (err_count !== seq[k]) $display("FAIL sat_seq k=%0d got %0d want %0d", k, err_count, seq[k]); else passed++;
      inc(LC);
    end
    checks++; if (n !== 5) $display("FAIL sat_pulses got %0d want 5", n); else passed++;
    cur++;
    go(cur, 1);
    checks++; if ({err_count, sticky_err} !== 3'b000) $display("FAIL clear got %b want 000", {err_count, sticky_err}); else passed++;
    checks++; if (locked !== 1'b1) $display("FAIL clear_lock got %b want 1", locked); else passed++;
    cur += 8'd9;
    go(cur, 1);
    checks++; if ({err_pulse, err_count, sticky_err} !== 4'b1011) $display("FAIL clear_coinc got %b want 1011", {err_pulse, err_count, sticky_err}); else passed++;
    inc(LC);
  endtask

  task automatic test_random();
    logic [7:0] v;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(cur + 8'd1);
      cur = v;
      go(v, $urandom_range(0, 19) == 0);
      checks++; if (got() !== want()) $display("FAIL rand_vec cyc=%0d got %h want %h", i, got(), want()); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    inc(LC + 1);
    cur++;
    go(cur, 1);
    repeat (2) begin
      cur += 8'd50;
      go(cur);
      inc(LC);
    end
    checks++; if ({locked, err_count} !== 3'b110) $display("FAIL mid_pre got %b want 110", {locked, err_count}); else passed++;
    go(8'h99, 0, 1);
    checks++; if (got() !== 14'h0) $display("FAIL mid_reset got %h want 0", got()); else passed++;
    cur = 8'h77;
    go(cur);
    checks++; if ({err_pulse, err_count, sticky_err} !== 4'b0) $display("FAIL mid_first got %b want 0000", {err_pulse, err_count, sticky_err}); else passed++;
    inc(LC);
    checks++; if (got() !== want() || locked !== 1'b1) $display("FAIL mid_relock got %h want %h", got(), want()); else passed++;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_counter_reset();
    test_stuck();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Receiving end of the free-running `counter` value bus: samples a WIDTH-bit count stream every clock.
- Checks that each sample equals the previous sample + 1 (mod 2^WIDTH).
- Reports lock status, per-cycle mismatch pulses, a saturating error count and wrap events.
- Sits beside `counter` in simulation benches and on-chip as a self-check monitor on any counter output.

Parameters:
- WIDTH, 8, bit width of the monitored value.
- LOCK_COUNT, 4, number of consecutive correct increments required to declare lock (≥1).
- ERR_WIDTH, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- value  input  WIDTH  counter value under test; sampled every rising edge.
- clear_err  input  1  synchronous clear of err_count and sticky_err.
- locked  output  1  high while in LOCKED state.
- err_pulse  output  1  one-cycle pulse per mismatch detected while LOCKED.
- err_count  output  ERR_WIDTH  number of mismatches; saturates at all-ones.
- sticky_err  output  1  set on the first mismatch; cleared only by reset or clear_err.
- wrap_pulse  output  1  one-cycle pulse when a correct all-ones→0 transition is seen while LOCKED.
- expected  output  WIDTH  registered prediction for the next sample (last sample + 1).

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, locked=0, err_pulse=0, wrap_pulse=0, err_count=0, sticky_err=0, expected=0, internal run counter=0.
  - Reset dominates clear_err and all other events in the same cycle.
- All outputs are registered. A sample taken at edge N affects outputs visible after edge N (one-cycle latency).
- "match" means value == expected, where expected = previous sample + 1 truncated to WIDTH. The all-ones→0 transition is a match.
- State machine:
  - IDLE:
    - Capture value; expected <= value+1; run <= 0; go to ACQUIRE.
    - The first cycle after reset release is always IDLE; its sample is never checked.
  - ACQUIRE:
    - On match: run <= run+1; if run+1 == LOCK_COUNT, go to LOCKED and set locked <= 1.
    - On mismatch: run <= 0; stay in ACQUIRE. No error is counted and err_pulse is not asserted.
  - LOCKED, on match: stay; wrap_pulse <= (value == 0).
  - LOCKED, on mismatch:
    - err_pulse <= 1; sticky_err <= 1; err_count <= err_count+1 unless already all-ones.
    - locked <= 0; run <= 0; go to ACQUIRE.
- expected <= value+1 every non-reset cycle in every state, so the checker resynchronises to the new sequence.
- A held (non-incrementing) value while LOCKED is one mismatch. The checker then stays in ACQUIRE until LOCK_COUNT increments resume.
- An in-line counter reset (value jumps to 0 from a non-all-ones value) while LOCKED counts as exactly one error. Relock takes LOCK_COUNT further cycles.
- clear_err:
  - Zeroes err_count and sticky_err next cycle; does not affect state or locked.
  - If a mismatch coincides with clear_err: err_count <= 1, sticky_err <= 1, err_pulse <= 1 (the new error wins over the clear).
- Saturation: at err_count = 2^ERR_WIDTH−1 further mismatches still pulse err_pulse, but the count holds.
- No X-propagation protection is required. An X on value after reset is treated by simulation semantics.

Decomposition:
- Shared package `counter_pkg`:
  - State encoding constants: IDLE=2'd0, ACQUIRE=2'd1, LOCKED=2'd2.
  - Default WIDTH=8, shared with `counter`.
- One sub-module, `sat_counter` (ERR_WIDTH, inc, clr, count), implements the saturating error counter. The same block is reused for run-length counting, with its width derived from LOCK_COUNT.
- FSM and comparison logic stay in `counter_checker`.

Test Plan:
- Lock after reset: drive `counter` (period 10) into the checker; reset high cycles 0–1 → IDLE at the first edge after release; locked=1 after 1+LOCK_COUNT=5 samples; err_count=0 throughout 200 cycles.
- Wrap: locked stream ...0xFE,0xFF,0x00 → wrap_pulse=1 for exactly one cycle after 0x00 is sampled; err_pulse stays 0.
- Mid-run counter reset: stream 0x1C→0x00 while locked → err_pulse one cycle; err_count=1; sticky_err=1; locked=0; locked=1 again 4 cycles later (at 0x04).
- Stuck value: hold 0x40 for 3 cycles while locked → exactly one err_pulse, err_count=1. Relock occurs 4 cycles after increments resume (run resets on each mismatch in ACQUIRE, which counts no errors).
- Saturation and clear: ERR_WIDTH=2, inject 5 locked mismatches with relock between each → err_count sequence 1,2,3,3,3 and 5 err_pulses. Then clear_err=1 → err_count=0, sticky_err=0. Mismatch coincident with clear_err → err_count=1.
- Reset mid-operation: assert reset while locked with err_count=2 → the next edge shows all outputs at reset values. The first post-reset sample is not checked, even if it is discontinuous.
